// File: rtl/shift_engine.sv
// Sequential shifter/rotator: one bit per cycle, done pulses amt+1 cycles after start (1 for pass/clear/amt=0).
// start is accepted only while idle; requests arriving while busy are dropped, not queued.
module shift_engine #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] word,
  input  logic [2:0]       sel,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] word_out,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_LSL = 3'b010;
  localparam logic [2:0] OP_CLR = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
  localparam logic [2:0] OP_ROL = 3'b110;

  state_t           state, state_n;
  logic [2:0]       mode, mode_n;
  logic [AMT_W-1:0] count, count_n;
  logic [WIDTH-1:0] word_n;
  logic             carry_n;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_LSR) || (op == OP_LSL) || (op == OP_ASR) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

  // Single 1-bit step; returns {exiting bit, new word}.
  function automatic logic [WIDTH:0] step1(input logic [2:0] op, input logic [WIDTH-1:0] w);
    logic [WIDTH:0] r;
    r = {1'b0, w};
    case (op)
      OP_LSR:  r = {w[0], 1'b0, w[WIDTH-1:1]};
      OP_ASR:  r = {w[0], w[WIDTH-1], w[WIDTH-1:1]};
      OP_ROR:  r = {w[0], w[0], w[WIDTH-1:1]};
      OP_LSL:  r = {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
      OP_ROL:  r = {w[WIDTH-1], w[WIDTH-2:0], w[WIDTH-1]};
      default: r = {1'b0, w};
    endcase
    return r;
  endfunction

  always_comb begin
    state_n = state;
    mode_n  = mode;
    count_n = count;
    word_n  = word_out;
    carry_n = carry_out;
    case (state)
      IDLE: begin
        if (start) begin
          mode_n  = sel;
          count_n = amt;
          carry_n = 1'b0;
          word_n  = (sel == OP_CLR) ? '0 : word;
          state_n = (is_shift(sel) && (amt != '0)) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        {carry_n, word_n} = step1(mode, word_out);
        count_n = count - 1'b1;
        if (count == AMT_W'(1)) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= '0;
      count     <= '0;
      word_out  <= '0;
      carry_out <= 1'b0;
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      count     <= count_n;
      word_out  <= word_n;
      carry_out <= carry_n;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_engine.sv
// Randomized bench for shift_engine against an arithmetic reference of each operation.
module tb_shift_engine;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] word;
  logic [2:0]       sel;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] word_out;
  logic             carry_out;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  shift_engine #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .word      (word),
    .sel       (sel),
    .amt       (amt),
    .word_out  (word_out),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_sh(input logic [2:0] s);
    return (s == 3'b001) || (s == 3'b010) || (s == 3'b100) || (s == 3'b101) || (s == 3'b110);
  endfunction

  // Whole-operation result {carry, word} computed directly from the amount.
  function automatic logic [8:0] ref_op(input logic [7:0] w, input logic [2:0] s, input int a);
    logic [7:0] r;
    logic       c;
    r = w;
    c = 1'b0;
    if (s == 3'b011) begin
      r = 8'h00;
    end else if (is_sh(s) && a != 0) begin
      case (s)
        3'b001: begin r = w >> a;                      c = w[a-1]; end
        3'b100: begin r = $signed(w) >>> a;            c = w[a-1]; end
        3'b101: begin r = (w >> a) | (w << (8 - a));   c = w[a-1]; end
        3'b010: begin r = w << a;                      c = w[8-a]; end
        default: begin r = (w << a) | (w >> (8 - a));  c = w[8-a]; end
      endcase
    end
    return {c, r};
  endfunction

  task automatic run_op(input logic [7:0] w, input logic [2:0] s, input logic [2:0] a, input bit inject);
    logic [8:0] e;
    int         lat;
    bit         seen;
    e    = ref_op(w, s, int'(a));
    lat  = (is_sh(s) && a != 0) ? 1 + int'(a) : 1;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1; word = w; sel = s; amt = a;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("busy_during_op", busy, 1);
      if (done) begin
        seen = 1'b1;
        check("latency", k, lat);
        check("result_word", word_out, e[7:0]);
        check("result_carry", carry_out, e[8]);
      end else if (inject && k == 1) begin
        // Junk request while busy; must be dropped.
        start = 1'b1; word = ~w; sel = 3'b011; amt = 3'd7;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_hold", word_out, e[7:0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] e;
    rst = 1'b1; start = 1'b0; word = '0; sel = '0; amt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_word", word_out, 0);
    check("rst_carry", carry_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Reset wins over a simultaneous start.
    start = 1'b1; word = 8'hAA; sel = 3'b000; amt = '0;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", busy, 0);
    check("rst_prio_word", word_out, 0);

    run_op(8'h96, 3'b100, 3'd3, 1'b0);
    run_op(8'h96, 3'b110, 3'd4, 1'b0);
    run_op(8'h81, 3'b010, 3'd1, 1'b0);
    run_op(8'h81, 3'b001, 3'd0, 1'b0);
    run_op(8'h3C, 3'b011, 3'd5, 1'b0);
    run_op(8'h5A, 3'b111, 3'd2, 1'b0);
    run_op(8'h80, 3'b001, 3'd7, 1'b1);
    run_op(8'h01, 3'b101, 3'd7, 1'b1);

    // Abort mid-rotate with an ignored start in flight.
    @(negedge clk);
    start = 1'b1; word = 8'hC3; sel = 3'b101; amt = 3'd6;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1);
    @(negedge clk);
    e = ref_op(8'hC3, 3'b101, 1);
    check("abort_step1", word_out, e[7:0]);
    start = 1'b1; word = 8'h11; sel = 3'b000; amt = '0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    e = ref_op(8'hC3, 3'b101, 2);
    check("ignored_start_word", word_out, e[7:0]);
    check("ignored_start_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_word", word_out, 0);
    check("abort_carry", carry_out, 0);
    check("abort_busy0", busy, 0);
    check("abort_done", done, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_abort_done", done, 0);
      check("post_abort_busy", busy, 0);
    end
    run_op(8'hC3, 3'b101, 3'd6, 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] rw;
      logic [2:0] rs;
      logic [2:0] ra;
      rw = 8'($urandom);
      rs = 3'($urandom_range(0, 7));
      ra = 3'($urandom_range(0, 7));
      run_op(rw, rs, ra, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter AMT_W, default $clog2(WIDTH), shift-amount field width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port start  input  1  request to begin an operation.
REQ-006 The block SHALL have port word  input  WIDTH  operand, sampled on accepted start.
REQ-007 The block SHALL have port sel  input  3  operation select, sampled on accepted start.
REQ-008 The block SHALL have port amt  input  AMT_W  shift count, sampled on accepted start.
REQ-009 The block SHALL have port word_out  output  WIDTH  working/result register.
REQ-010 The block SHALL have port carry_out  output  1  last bit shifted or rotated out.
REQ-011 The block SHALL have port busy  output  1  high while an operation is in progress.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse marking a valid result.

Function
REQ-013 The block SHALL decode sel as: 000 pass, 001 logical right, 010 logical left, 011 clear, 100 arithmetic right, 101 rotate right, 110 rotate left, 111 pass.
REQ-014 The block SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 The block SHALL accept start only in IDLE; start in SHIFT or DONE SHALL be ignored with no effect on state or outputs.
REQ-016 On accepted start at edge t, the block SHALL load word into word_out, capture sel and amt, clear carry_out, and go to SHIFT if sel is a shift/rotate code and amt != 0, else to DONE.
REQ-017 In SHIFT, each cycle SHALL perform exactly one 1-bit operation of the captured mode on word_out and decrement the remaining count; at the edge where count reaches 0 the FSM SHALL go to DONE.
REQ-018 Logical right SHALL fill MSB with 0; logical left SHALL fill LSB with 0; arithmetic right SHALL replicate the MSB; rotates SHALL feed the exiting bit into the vacated end.
REQ-019 On each 1-bit step, carry_out SHALL take the exiting bit (bit 0 for right modes, bit WIDTH-1 for left modes).
REQ-020 For clear (011), word_out SHALL be 0 and carry_out 0 in DONE; for pass modes or amt=0, word_out SHALL equal word and carry_out 0.
REQ-021 done SHALL be 1 for exactly the single cycle spent in DONE; the FSM SHALL then return to IDLE.
REQ-022 Latency: done SHALL be high in cycle t+1+amt for shift/rotate modes with amt != 0, and in cycle t+1 otherwise.
REQ-023 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-024 word_out SHALL show intermediate values during SHIFT; it is valid only when done=1 and SHALL hold that value in IDLE until the next accepted start.
REQ-025 amt values >= WIDTH SHALL be executed literally (one step per count), so rotates wrap and logical shifts saturate to all-fill.

Reset
REQ-026 When rst=1 at a rising edge, the block SHALL go to IDLE with word_out=0, carry_out=0, busy=0, done=0, count=0, regardless of state, including mid-SHIFT.
REQ-027 rst SHALL take priority over start in the same cycle.

Verification (WIDTH=8)
REQ-028 Start, word=8'h96, sel=100, amt=3 -> done at t+4, word_out=8'hF2, carry_out=1, busy high t+1..t+4.
REQ-029 Start, word=8'h96, sel=110, amt=4 -> done at t+5, word_out=8'h69, carry_out=1.
REQ-030 Start, word=8'h81, sel=010, amt=1 -> done at t+2, word_out=8'h02, carry_out=1; then start, sel=001, amt=0 -> done at next cycle, word_out=word, carry_out=0.
REQ-031 Start, sel=011 -> done at t+1, word_out=8'h00; start with sel=111, word=8'h5A -> word_out=8'h5A at done.
REQ-032 Start, sel=101, amt=6; pulse start with new operands at t+2 and assert rst at t+4 -> second start ignored, all outputs 0 and busy=0 after the reset edge, no done pulse; fresh start then completes normally.
